// File: rtl/program_ram_pkg.sv
// Shared widths, depth and loader state encoding for the program RAM slice.
package program_ram_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned RAM_DEPTH  = 16;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/program_ram_ram_array.sv
// Register-file storage: one synchronous write port, one combinational read port, no reset.
module ram_array
  import program_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_ram.sv
// Program/data RAM with W-bus read gating and a valid/ready loader FSM.
module program_ram
  import program_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ram_addres,
  input  logic              ce_n,
  output logic [DATA_W-1:0] w_bus_out,
  output logic              w_bus_oe,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [ADDR_W-1:0] prog_ptr,
  output logic [DATA_W-1:0] prog_sum
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] rdata;
  logic              we;

  // Dropping prog_mode aborts before the byte lands; reset also blocks the write.
  assign we = (state_q == LOAD) && prog_mode && prog_valid && !rst;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:  if (prog_mode) state_d = LOAD;
      LOAD: begin
        if (!prog_mode)                   state_d = RUN;
        else if (prog_valid && ptr_q == '1) state_d = DONE;
      end
      DONE: if (!prog_mode) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ptr_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN && prog_mode) begin
        ptr_q <= '0;
        sum_q <= '0;
      end else if (we) begin
        ptr_q <= ptr_q + 1'b1;
        sum_q <= sum_q + prog_data;
      end
    end
  end

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (2**ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (ptr_q),
    .wdata (prog_data),
    .raddr (ram_addres),
    .rdata (rdata)
  );

  assign prog_ready = (state_q == LOAD);
  assign prog_done  = (state_q == DONE);
  assign prog_ptr   = ptr_q;
  assign prog_sum   = sum_q;
  assign w_bus_oe   = (state_q == RUN) && !ce_n;
  assign w_bus_out  = w_bus_oe ? rdata : '0;

endmodule

// File: tb/tb_program_ram.sv
// Directed self-checking bench for program_ram: load, readback, throttled load, abort, reset.
module tb_program_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ram_addres;
  logic       ce_n;
  logic [7:0] w_bus_out;
  logic       w_bus_oe;
  logic       prog_mode;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready;
  logic       prog_done;
  logic [3:0] prog_ptr;
  logic [7:0] prog_sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  program_ram #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ram_addres (ram_addres),
    .ce_n       (ce_n),
    .w_bus_out  (w_bus_out),
    .w_bus_oe   (w_bus_oe),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .prog_ptr   (prog_ptr),
    .prog_sum   (prog_sum)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce_n = 1'b1; ram_addres = '0;
    prog_mode = 1'b0; prog_valid = 1'b0; prog_data = '0;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", prog_ready); end
    checks++; if (prog_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", prog_done); end
    checks++; if (prog_ptr !== 4'h0) begin errors++; $display("FAIL reset_ptr got=%h exp=0", prog_ptr); end
    checks++; if (prog_sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", prog_sum); end
    checks++; if (w_bus_oe !== 1'b0 || w_bus_out !== 8'h00) begin errors++; $display("FAIL reset_bus got oe=%b out=%h exp oe=0 out=00", w_bus_oe, w_bus_out); end
  endtask

  task automatic test_back_to_back();
    ce_n = 1'b0;
    prog_mode = 1'b1;
    #1;
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL b2b_entry_latency got=%b exp=0", prog_ready); end
    step();
    for (int i = 0; i < 16; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'h10 + 8'(i);
      #1;
      checks++; if (prog_ready !== 1'b1 || prog_ptr !== 4'(i)) begin errors++; $display("FAIL b2b_xfer%0d got ready=%b ptr=%h exp ready=1 ptr=%h", i, prog_ready, prog_ptr, 4'(i)); end
      checks++; if (w_bus_oe !== 1'b0 || w_bus_out !== 8'h00) begin errors++; $display("FAIL load_oe_gated%0d got oe=%b out=%h exp 0/00", i, w_bus_oe, w_bus_out); end
      step();
    end
    prog_valid = 1'b0;
    #1;
    checks++; if (prog_done !== 1'b1 || prog_ready !== 1'b0) begin errors++; $display("FAIL b2b_done got done=%b ready=%b exp 1/0", prog_done, prog_ready); end
    checks++; if (prog_sum !== 8'h78) begin errors++; $display("FAIL b2b_sum got=%h exp=78", prog_sum); end
    checks++; if (prog_ptr !== 4'h0) begin errors++; $display("FAIL b2b_ptr got=%h exp=0", prog_ptr); end
    checks++; if (w_bus_oe !== 1'b0) begin errors++; $display("FAIL done_oe_gated got=%b exp=0", w_bus_oe); end
    step();
    checks++; if (prog_done !== 1'b1) begin errors++; $display("FAIL done_hold got=%b exp=1", prog_done); end
  endtask

  task automatic test_readback();
    prog_mode = 1'b0;
    step();
    prog_valid = 1'b1; prog_data = 8'hEE;
    ce_n = 1'b0;
    for (int a = 0; a < 16; a++) begin
      ram_addres = 4'(a);
      #1;
      checks++; if (w_bus_oe !== 1'b1 || w_bus_out !== 8'h10 + 8'(a)) begin errors++; $display("FAIL read%0d got oe=%b out=%h exp oe=1 out=%h", a, w_bus_oe, w_bus_out, 8'h10 + 8'(a)); end
    end
    step();
    checks++; if (prog_ready !== 1'b0 || prog_ptr !== 4'h0) begin errors++; $display("FAIL run_ignores_valid got ready=%b ptr=%h exp 0/0", prog_ready, prog_ptr); end
    prog_valid = 1'b0;
    ce_n = 1'b1;
    #1;
    checks++; if (w_bus_oe !== 1'b0 || w_bus_out !== 8'h00) begin errors++; $display("FAIL read_disabled got oe=%b out=%h exp 0/00", w_bus_oe, w_bus_out); end
  endtask

  task automatic test_toggle_valid();
    int k = 0;
    prog_mode = 1'b1;
    step();
    for (int c = 0; c < 31; c++) begin
      prog_valid = (c % 2 == 0);
      prog_data  = (k % 2 == 0) ? 8'hAA : 8'h55;
      #1;
      checks++; if (prog_ptr !== 4'(k) || prog_done !== 1'b0) begin errors++; $display("FAIL toggle_c%0d got ptr=%h done=%b exp ptr=%h done=0", c, prog_ptr, prog_done, 4'(k)); end
      if (prog_valid) k++;
      step();
    end
    prog_valid = 1'b0;
    #1;
    checks++; if (prog_done !== 1'b1) begin errors++; $display("FAIL toggle_done got=%b exp=1", prog_done); end
    checks++; if (prog_sum !== 8'hF8) begin errors++; $display("FAIL toggle_sum got=%h exp=F8", prog_sum); end
    prog_mode = 1'b0;
    step();
    ce_n = 1'b0;
    for (int a = 0; a < 16; a++) begin
      ram_addres = 4'(a);
      #1;
      checks++; if (w_bus_out !== ((a % 2 == 0) ? 8'hAA : 8'h55)) begin errors++; $display("FAIL toggle_read%0d got=%h exp=%h", a, w_bus_out, (a % 2 == 0) ? 8'hAA : 8'h55); end
    end
    ce_n = 1'b1;
  endtask

  task automatic test_abort();
    prog_mode = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'h60 + 8'(i);
      step();
    end
    prog_mode = 1'b0; prog_data = 8'h99;
    step();
    prog_valid = 1'b0;
    #1;
    checks++; if (prog_ready !== 1'b0 || prog_done !== 1'b0) begin errors++; $display("FAIL abort_state got ready=%b done=%b exp 0/0", prog_ready, prog_done); end
    checks++; if (prog_ptr !== 4'h5 || prog_sum !== 8'hEA) begin errors++; $display("FAIL abort_hold got ptr=%h sum=%h exp 5/EA", prog_ptr, prog_sum); end
    ce_n = 1'b0;
    for (int a = 0; a < 6; a++) begin
      ram_addres = 4'(a);
      #1;
      checks++; if (w_bus_out !== ((a == 5) ? 8'h55 : 8'h60 + 8'(a))) begin errors++; $display("FAIL abort_read%0d got=%h exp=%h", a, w_bus_out, (a == 5) ? 8'h55 : 8'h60 + 8'(a)); end
    end
    ce_n = 1'b1;
    prog_mode = 1'b1;
    step();
    checks++; if (prog_ptr !== 4'h0 || prog_sum !== 8'h00 || prog_ready !== 1'b1) begin errors++; $display("FAIL reenter got ptr=%h sum=%h ready=%b exp 0/00/1", prog_ptr, prog_sum, prog_ready); end
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 9; i++) begin
      prog_valid = 1'b1;
      prog_data  = 8'h80 + 8'(i);
      step();
    end
    checks++; if (prog_ptr !== 4'h9) begin errors++; $display("FAIL midload_ptr got=%h exp=9", prog_ptr); end
    rst = 1'b1; prog_data = 8'hEE;
    step();
    rst = 1'b0; prog_mode = 1'b0; prog_valid = 1'b0;
    #1;
    checks++; if (prog_ptr !== 4'h0 || prog_sum !== 8'h00) begin errors++; $display("FAIL midrst_regs got ptr=%h sum=%h exp 0/00", prog_ptr, prog_sum); end
    checks++; if (prog_ready !== 1'b0 || prog_done !== 1'b0) begin errors++; $display("FAIL midrst_flags got ready=%b done=%b exp 0/0", prog_ready, prog_done); end
    ce_n = 1'b0;
    for (int a = 0; a < 10; a++) begin
      ram_addres = 4'(a);
      #1;
      checks++; if (w_bus_oe !== 1'b1 || w_bus_out !== ((a == 9) ? 8'h55 : 8'h80 + 8'(a))) begin errors++; $display("FAIL midrst_read%0d got oe=%b out=%h exp oe=1 out=%h", a, w_bus_oe, w_bus_out, (a == 9) ? 8'h55 : 8'h80 + 8'(a)); end
    end
    ce_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_readback();
    test_toggle_valid();
    test_abort();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
